fetch_prefetch_buf: RTL

FETCH_PREFETCH_BUF -- requirements
Module: fetch_prefetch_buf

---
 rtl/fetch_prefetch_buf_if.sv | 26 ++
 rtl/fetch_prefetch_buf.sv | 105 ++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buf_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response, and decode-side queue head.
// The master modport is the fetch unit; the slave modport is its environment (memory, execute, decode).
interface fetch_prefetch_buf_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic        rsp_err;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
      output imem_req_valid, imem_addr, out_valid, out_instr, out_pc, rsp_err
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
      input  imem_req_valid, imem_addr, out_valid, out_instr, out_pc, rsp_err
   );
endinterface

// File: rtl/fetch_prefetch_buf.sv
// Instruction prefetch buffer: issues sequential fetches, queues in-order responses for decode,
// and discards responses belonging to a stream abandoned by a redirect.
module fetch_prefetch_buf #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                  clk,
   input logic                  reset,
   fetch_prefetch_buf_if.master bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic          rsp_err_q, rsp_err_d;
   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem [DEPTH];
   logic [CW:0]   occupancy;
   logic          not_empty, req_fire, rsp_ok, push, pop;
   logic [31:0]   redirect_tgt;

   // Reserving queue slots for in-flight requests is what makes overflow impossible.
   assign occupancy    = {1'b0, count_q} + {1'b0, inflight_q};
   assign not_empty    = (count_q != '0);
   assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};

   assign bus.imem_req_valid = reset & ~bus.redirect_valid & (occupancy < DEPTH_W);
   assign bus.imem_addr      = fetch_pc_q;
   assign bus.out_valid      = not_empty & ~bus.redirect_valid;
   assign bus.out_instr      = not_empty ? instr_mem[rd_ptr_q] : '0;
   assign bus.out_pc         = not_empty ? pc_mem[rd_ptr_q] : '0;
   assign bus.rsp_err        = rsp_err_q;

   assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
   assign pop      = bus.out_valid & bus.out_ready;
   assign rsp_ok   = bus.imem_rsp_valid & (inflight_q != '0);
   assign push     = rsp_ok & (drop_q == '0) & ~bus.redirect_valid;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      count_d    = count_q;
      drop_d     = drop_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      rsp_err_d  = rsp_err_q | (bus.imem_rsp_valid & (inflight_q == '0));
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
      if (bus.redirect_valid) begin
         fetch_pc_d = redirect_tgt;
         resp_pc_d  = redirect_tgt;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         // Every response still owed after this cycle belongs to the abandoned stream.
         drop_d     = inflight_d;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (rsp_ok && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
         end
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= bus.imem_rsp_data;
         pc_mem[wr_ptr_q]    <= resp_pc_q;
      end
   end
endmodule
